// File: rtl/dedup_stream_if.sv
// Generator handshake bundle for dedup_stream: caller-side ready/valid/done plus the
// child-source ready/valid/done channel the stage drives as a caller.
interface dedup_stream_if #(
  parameter int WIDTH = 32
);
  logic                    _start;
  logic                    _ready;
  logic                    _valid;
  logic                    _done;
  logic signed [WIDTH-1:0] _0;
  logic                    _src_start;
  logic                    _src_ready;
  logic                    _src_valid;
  logic                    _src_done;
  logic signed [WIDTH-1:0] _src_0;

  modport slave (
    input  _start, _ready, _src_valid, _src_done, _src_0,
    output _valid, _done, _0, _src_start, _src_ready
  );

  modport master (
    output _start, _ready, _src_valid, _src_done, _src_0,
    input  _valid, _done, _0, _src_start, _src_ready
  );
endinterface

// File: rtl/dedup_stream.sv
// Re-emits a child generator's stream with runs of equal consecutive values collapsed
// to one beat; presents the standard generator interface upward.
module dedup_stream #(
  parameter int WIDTH = 32
) (
  input logic           _clock,
  input logic           _reset,
  dedup_stream_if.slave bus
);

  typedef enum logic {S_DONE, S_FETCH} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_valid, w_valid;
  logic                    r_done, w_done;
  logic                    r_src_start, w_src_start;
  logic                    r_src_ready, w_src_ready;
  logic                    r_first, w_first;
  logic signed [WIDTH-1:0] r_data, w_data;
  logic signed [WIDTH-1:0] r_last, w_last;

  logic w_advance;
  logic w_accept;
  logic w_emit;

  always_comb begin
    w_advance = bus._ready || !r_valid;
    w_accept  = r_src_ready && bus._src_valid;
    w_emit    = r_first || (bus._src_0 != r_last);
  end

  always_ff @(posedge _clock) begin
    r_state     <= w_state_nxt;
    r_valid     <= w_valid;
    r_done      <= w_done;
    r_src_start <= w_src_start;
    r_src_ready <= w_src_ready;
    r_first     <= w_first;
    r_data      <= w_data;
    r_last      <= w_last;
  end

  // Start wins over reset; source done ends the stream whether or not a beat was taken.
  always_comb begin
    w_state_nxt = r_state;
    if (bus._start) begin
      w_state_nxt = S_FETCH;
    end else if (_reset) begin
      w_state_nxt = S_DONE;
    end else if (w_advance && r_state == S_FETCH && bus._src_done) begin
      w_state_nxt = S_DONE;
    end
  end

  always_comb begin
    w_done      = 1'b0;
    w_valid     = bus._ready ? 1'b0 : r_valid;
    w_src_start = r_src_start;
    w_src_ready = r_src_ready;
    w_first     = r_first;
    w_data      = r_data;
    w_last      = r_last;
    if (bus._start) begin
      w_first     = 1'b1;
      w_src_start = 1'b1;
      w_src_ready = 1'b0;
    end else if (_reset) begin
      w_src_start = 1'b0;
      w_src_ready = 1'b0;
      w_valid     = 1'b0;
      w_data      = '0;
    end else if (w_advance) begin
      case (r_state)
        S_DONE: w_done = 1'b1;
        S_FETCH: begin
          w_src_start = 1'b0;
          w_src_ready = 1'b1;
          if (w_accept) begin
            w_src_ready = 1'b0;
            if (!bus._src_done && w_emit) begin
              w_data  = bus._src_0;
              w_last  = bus._src_0;
              w_first = 1'b0;
              w_valid = 1'b1;
            end
          end
        end
        default: w_done = 1'b0;
      endcase
    end
  end

  assign bus._valid     = r_valid;
  assign bus._done      = r_done;
  assign bus._0         = r_data;
  assign bus._src_start = r_src_start;
  assign bus._src_ready = r_src_ready;

endmodule

// File: tb/tb_dedup_stream.sv
// Scoreboard bench for dedup_stream: directed source lists, expected outputs queued at
// stimulus time and checked by a separate negedge monitor.
module tb_dedup_stream;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dedup_stream_if #(.WIDTH(W)) bus ();
  dedup_stream #(.WIDTH(W)) dut (._clock(clk), ._reset(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;
  logic signed [W-1:0] exp_q[$];
  bit mon_en = 1'b0;
  bit chk_excl = 1'b0;

  // Source model: list loaded by the stimulus, index restarted on the caller's start edge.
  logic signed [W-1:0] m_arr[16];
  int m_len = 0;
  int m_idx = 0;
  int m_acc = 0;

  assign bus._src_valid = (m_idx < m_len);
  assign bus._src_done  = (m_idx >= m_len);
  assign bus._src_0     = (m_idx < m_len) ? m_arr[m_idx[3:0]] : '0;

  always @(posedge clk) begin
    if (bus._start) begin
      m_idx <= 0;
    end else if (bus._src_ready && bus._src_valid) begin
      m_idx <= m_idx + 1;
      m_acc <= m_acc + 1;
    end
  end

  task automatic chk_val(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus._valid && bus._ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got %0d expected no beat", bus._0);
        end else begin
          chk_val("out", bus._0, exp_q.pop_front());
        end
        n_out++;
      end
      if (chk_excl && bus._done) chk_bit("valid_after_done", bus._valid, 1'b0);
    end
  end

  task automatic src_clear();
    m_len = 0;
  endtask

  task automatic src_push(input logic signed [W-1:0] v);
    m_arr[m_len] = v;
    m_len++;
  endtask

  // Called at posedge+1 with _ready high; returns at posedge+1 after edge N+1.
  task automatic do_start(input bit with_reset);
    bus._start = 1'b1;
    rst = with_reset;
    @(posedge clk); #1;
    bus._start = 1'b0;
    rst = 1'b0;
    chk_bit("src_start_pulse", bus._src_start, 1'b1);
    chk_bit("src_ready_in_start", bus._src_ready, 1'b0);
    @(posedge clk); #1;
    chk_bit("src_start_drop", bus._src_start, 1'b0);
    chk_bit("src_ready_rise", bus._src_ready, 1'b1);
  endtask

  task automatic wait_end(input string name);
    for (int i = 0; i < 200; i++) begin
      if (bus._done && exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk_bit({name, "_done"}, bus._done, 1'b1);
    chk_val({name, "_pending"}, W'(exp_q.size()), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int a0;
    rst = 1'b1;
    bus._start = 1'b0;
    bus._ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_bit("rst_valid", bus._valid, 1'b0);
    chk_bit("rst_src_start", bus._src_start, 1'b0);
    chk_bit("rst_src_ready", bus._src_ready, 1'b0);
    chk_bit("rst_done", bus._done, 1'b0);
    chk_val("rst_out", bus._0, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_bit("done_after_rst", bus._done, 1'b1);
    mon_en = 1'b1;

    // dup_range_goal(0,10,2)
    src_clear();
    for (int v = 0; v < 10; v += 2) begin
      src_push(W'(v));
      src_push(W'(v));
      exp_q.push_back(W'(v));
    end
    chk_excl = 1'b1;
    do_start(1'b0);
    wait_end("range");
    repeat (4) begin
      @(posedge clk); #1;
      chk_bit("done_held", bus._done, 1'b1);
    end
    chk_excl = 1'b0;

    // empty source
    src_clear();
    base = n_out;
    do_start(1'b0);
    chk_bit("empty_done_early", bus._done, 1'b0);
    @(posedge clk); #1;
    chk_bit("empty_done", bus._done, 1'b1);
    chk_val("empty_no_beats", W'(n_out - base), '0);

    // only adjacent duplicates collapse; -1 and all-ones are equal
    src_clear();
    src_push(3); src_push(3); src_push(5); src_push(3); src_push(-1); src_push(32'hFFFF_FFFF);
    exp_q.push_back(3); exp_q.push_back(5); exp_q.push_back(3); exp_q.push_back(-1);
    do_start(1'b0);
    wait_end("adjacent");

    // backpressure on the beat carrying 2
    src_clear();
    src_push(0); src_push(0); src_push(2); src_push(2); src_push(4); src_push(4);
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(4);
    do_start(1'b0);
    for (int i = 0; i < 100; i++) begin
      if (bus._valid && bus._0 == 2) break;
      @(posedge clk); #1;
    end
    chk_val("stall_target", bus._0, 2);
    bus._ready = 1'b0;
    a0 = m_acc;
    repeat (5) begin
      @(negedge clk);
      chk_val("stall_hold", bus._0, 2);
      chk_bit("stall_valid", bus._valid, 1'b1);
      @(posedge clk); #1;
    end
    chk_val("stall_no_accept", W'(m_acc), W'(a0));
    bus._ready = 1'b1;
    wait_end("stall");

    // reset after the second output, then restart with a value equal to last
    src_clear();
    src_push(0); src_push(0); src_push(2); src_push(2); src_push(4); src_push(4);
    exp_q.push_back(0); exp_q.push_back(2);
    base = n_out;
    do_start(1'b0);
    for (int i = 0; i < 100; i++) begin
      if (n_out == base + 2) break;
      @(posedge clk); #1;
    end
    chk_val("two_outputs", W'(n_out - base), 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_bit("midrst_valid", bus._valid, 1'b0);
    chk_bit("midrst_src_ready", bus._src_ready, 1'b0);
    chk_bit("midrst_done_early", bus._done, 1'b0);
    @(posedge clk); #1;
    chk_bit("midrst_done", bus._done, 1'b1);
    src_clear();
    src_push(2); src_push(2); src_push(7);
    exp_q.push_back(2); exp_q.push_back(7);
    do_start(1'b0);
    wait_end("restart");

    // start and reset together behaves as start
    src_clear();
    src_push(1); src_push(1); src_push(9);
    exp_q.push_back(1); exp_q.push_back(9);
    do_start(1'b1);
    wait_end("start_rst");

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
